soc_bus_sequencer: RTL and testbench
====================================

# soc_bus_sequencer

Slave-side transaction sequencer for the unified SoC bus, placed after the instruction/data RAM arbiter. It accepts one OBI transaction at a time and decodes `addr_i[31:24]` to a local region (data RAM, instruction/flash RAM, UART) or an external region (I2C, pinmux). It generates `gnt_o`/`rvalid_o` and a one-cycle access strobe for the local memories and peripherals. It also runs the external OBI handshake under a timeout and returns an error response for unmapped or timed-out accesses.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles allowed in each external phase before abort; legal range 2..255.
- `ERR_RDATA`, default 32'hBAD0_BAD0: read data returned on any error response.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `req_i`  in  1  bus request.
- `addr_i`  in  32  request address.
- `we_i`  in  1  write enable.
- `be_i`  in  4  byte enables.
- `wdata_i`  in  32  write data.
- `gnt_o`  out  1  grant; one-cycle pulse.
- `rvalid_o`  out  1  response valid; one-cycle pulse.
- `rdata_o`  out  32  response data; valid while `rvalid_o` is high.
- `err_o`  out  1  error flag; pulses together with `rvalid_o` on error responses.
- `loc_sel_o`  out  3  one-hot local select: bit0 RAM (0x00), bit1 flash (0x02), bit2 UART (0x0A).
- `loc_strobe_o`  out  1  local access strobe, coincident with `gnt_o`.
- `loc_addr_o`  out  32  latched request address.
- `loc_we_o`  out  1  latched write enable.
- `loc_be_o`  out  4  latched byte enables.
- `loc_wdata_o`  out  32  latched write data.
- `ram_rdata_i`  in  32  data RAM read data.
- `flash_rdata_i`  in  32  flash RAM read data.
- `uart_rdata_i`  in  32  UART read data.
- `ext_req_o`  out  1  external OBI request.
- `ext_gnt_i`  in  1  external OBI grant.
- `ext_rvalid_i`  in  1  external OBI response valid.
- `ext_rdata_i`  in  32  external OBI read data.
- `err_cnt_o`  out  8  count of error responses; saturates at 255.
- `err_addr_o`  out  32  address of the most recent error response.

## Operation
- Address, `we`, `be` and `wdata` are latched into the `loc_*` registers when a request is accepted (IDLE, or RESP with `req_i` high). The `loc_*` registers hold their value until the next accept.
- Region decode uses the latched `addr[31:24]`: 0x00, 0x02 and 0x0A are local; 0x0E and 0x0F are external; every other value is unmapped.
- States:
  - IDLE: on `req_i`, latch the request and go to LGNT (local or unmapped) or EREQ (external).
  - LGNT: `gnt_o`=1. `loc_strobe_o`=1 only if the region is local. Go to RESP.
  - EREQ: `ext_req_o`=1. On `ext_gnt_i` go to EGNT. On timeout, drop `ext_req_o` and go to RESP with error.
  - EGNT: `gnt_o`=1. Go to EWAIT.
  - EWAIT: on `ext_rvalid_i`, register `ext_rdata_i` and go to RESP. On timeout, set `stale` and go to RESP with error.
  - RESP: `rvalid_o`=1. If `req_i` is high, accept exactly as in IDLE; otherwise go to IDLE.
- RESP data: local region gives the matching `*_rdata_i`, sampled combinationally in RESP. External region gives the registered `ext_rdata_i`. Error gives `ERR_RDATA` with `err_o`=1.
- Writes to unmapped regions: `gnt_o` and `rvalid_o` still pulse, `err_o`=1, and no strobe is issued.
- Timeout counter: cleared on entry to EREQ and to EWAIT, and increments each cycle in those states. Timeout fires when the counter equals `TIMEOUT_CYCLES`-1, i.e. the phase lasts `TIMEOUT_CYCLES` cycles.
- `stale`: while set, the next `ext_rvalid_i` is discarded and clears `stale`. While `stale` is set, external requests wait in IDLE without being accepted; local requests proceed. `stale` also self-clears after `TIMEOUT_CYCLES` cycles.
- Every error response increments `err_cnt_o` (saturating) and loads `err_addr_o`.
- Reset values: state IDLE; `stale`=0; `err_cnt_o`=0; `err_addr_o`=0; all `loc_*` registers 0; all pulse outputs 0; `rdata_o`=0.

## Timing
- Local access: `req_i` sampled at edge N gives `gnt_o`/`loc_strobe_o` in cycle N+1 and `rvalid_o` in cycle N+2. Back-to-back throughput is one transaction per 2 cycles.
- Memories and UART must present read data in the cycle after the strobe (one-cycle synchronous read).
- External access: `ext_req_o` is asserted the cycle after accept. `gnt_o` follows the cycle after `ext_gnt_i`. `rvalid_o` follows the cycle after `ext_rvalid_i`.
- `ext_gnt_i` or `ext_rvalid_i` in any state other than its waiting state is ignored, with the exception of the `stale` discard.
- Reset asserted mid-transaction: immediate return to IDLE. All outputs go low in the same cycle (asynchronous). No response is ever issued for the aborted transaction.

## Test plan
- Local read/write sequence:
  - Read 0x0000_0010 with RAM data 0x1234_5678 gives `gnt_o` at N+1, `rvalid_o` at N+2 and `rdata_o`=0x1234_5678.
  - Write to 0x0200_0004 gives `loc_sel_o`=3'b010, `loc_strobe_o`=1 and `loc_we_o`=1.
- Back-to-back: `req_i` held for 4 RAM reads gives 4 `gnt_o` pulses on alternate cycles and 4 `rvalid_o` pulses in order.
- Unmapped access: read 0x5000_0000 gives `rdata_o`=0xBAD0_BAD0, `err_o`=1, `err_cnt_o`=1, `err_addr_o`=0x5000_0000, and no `loc_strobe_o`.
- External delays: I2C read with `ext_gnt_i` delayed 3 cycles and `ext_rvalid_i` delayed 5 cycles with data 0xA5 gives `gnt_o` 1 cycle after grant, and `rvalid_o` plus data 0xA5 1 cycle after rvalid.
- External timeouts, with `TIMEOUT_CYCLES`=8:
  - `ext_gnt_i` never asserted: `ext_req_o` drops after 8 cycles and the error response follows.
  - `ext_rvalid_i` arriving late: it is discarded and the next external transaction completes correctly.
- Edge cases:
  - Reset pulsed while in EWAIT returns the block to idle with no `rvalid_o`.
  - 256 unmapped accesses saturate `err_cnt_o` at 255.

Source files
------------

// File: rtl/soc_bus_sequencer.sv
// soc_bus_sequencer: slave-side OBI sequencer behind the RAM arbiter.
// Decodes addr[31:24] to a local region (RAM 0x00, flash 0x02, UART 0x0A)
// or an external region (0x0E I2C, 0x0F pinmux), runs the external
// handshake under a timeout, and returns error responses for unmapped
// or timed-out accesses.
//
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   req_i/addr_i/we_i/be_i/wdata_i   incoming bus request
//   gnt_o, rvalid_o, rdata_o, err_o  bus handshake and response
//   loc_sel_o, loc_strobe_o, loc_*   latched request + strobe to local slaves
//   ram/flash/uart_rdata_i        local read data (one-cycle sync read)
//   ext_req_o/ext_gnt_i/ext_rvalid_i/ext_rdata_i  external OBI port
//   err_cnt_o, err_addr_o         saturating error count, last error address
module soc_bus_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hBAD0_BAD0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [2:0]  loc_sel_o,
    output logic        loc_strobe_o,
    output logic [31:0] loc_addr_o,
    output logic        loc_we_o,
    output logic [3:0]  loc_be_o,
    output logic [31:0] loc_wdata_o,
    input  logic [31:0] ram_rdata_i,
    input  logic [31:0] flash_rdata_i,
    input  logic [31:0] uart_rdata_i,
    output logic        ext_req_o,
    input  logic        ext_gnt_i,
    input  logic        ext_rvalid_i,
    input  logic [31:0] ext_rdata_i,
    output logic [7:0]  err_cnt_o,
    output logic [31:0] err_addr_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LGNT,
        S_EREQ,
        S_EGNT,
        S_EWAIT,
        S_RESP
    } state_e;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic [7:0]  tmo_q;
    logic        stale_q;
    logic [7:0]  stale_cnt_q;
    logic [31:0] addr_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [2:0]  sel_q;
    logic        ext_q;
    logic        gnt_q;
    logic        strobe_q;
    logic        rvalid_q;
    logic        err_q;
    logic        ext_req_q;
    logic [31:0] ext_rdata_q;
    logic [7:0]  err_cnt_q;
    logic [31:0] err_addr_q;

    logic [2:0]  req_sel;
    logic        req_ext;
    logic        accept;
    logic        tmo_hit;
    logic        err_evt;

    // Decode of the incoming address, used only to pick the next state
    // at accept time; later states use the latched copy.
    always_comb begin
        req_sel = 3'b000;
        req_ext = 1'b0;
        case (addr_i[31:24])
            8'h00:        req_sel = 3'b001;
            8'h02:        req_sel = 3'b010;
            8'h0A:        req_sel = 3'b100;
            8'h0E, 8'h0F: req_ext = 1'b1;
            default:      ;
        endcase
    end

    // External requests are held off while a late response is still owed.
    assign accept  = req_i && !(req_ext && stale_q);
    assign tmo_hit = (tmo_q == TMO_LAST);

    always_comb begin
        err_evt = 1'b0;
        case (state_q)
            S_LGNT:  err_evt = (sel_q == 3'b000);
            S_EREQ:  err_evt = !ext_gnt_i && tmo_hit;
            S_EWAIT: err_evt = !ext_rvalid_i && tmo_hit;
            default: err_evt = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            tmo_q       <= '0;
            stale_q     <= 1'b0;
            stale_cnt_q <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            sel_q       <= '0;
            ext_q       <= 1'b0;
            gnt_q       <= 1'b0;
            strobe_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            ext_req_q   <= 1'b0;
            ext_rdata_q <= '0;
            err_cnt_q   <= '0;
            err_addr_q  <= '0;
        end else begin
            gnt_q    <= 1'b0;
            strobe_q <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;

            // Stale window: first external rvalid is swallowed, or the
            // window closes by itself after TIMEOUT_CYCLES cycles.
            if (stale_q) begin
                if (ext_rvalid_i || stale_cnt_q == TMO_LAST) begin
                    stale_q <= 1'b0;
                end else begin
                    stale_cnt_q <= stale_cnt_q + 8'd1;
                end
            end

            if (err_evt) begin
                err_q      <= 1'b1;
                err_addr_q <= addr_q;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end

            case (state_q)
                S_IDLE, S_RESP: begin
                    if (accept) begin
                        addr_q  <= addr_i;
                        we_q    <= we_i;
                        be_q    <= be_i;
                        wdata_q <= wdata_i;
                        sel_q   <= req_sel;
                        ext_q   <= req_ext;
                        if (req_ext) begin
                            state_q   <= S_EREQ;
                            ext_req_q <= 1'b1;
                            tmo_q     <= '0;
                        end else begin
                            state_q  <= S_LGNT;
                            gnt_q    <= 1'b1;
                            strobe_q <= |req_sel;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_LGNT: begin
                    state_q  <= S_RESP;
                    rvalid_q <= 1'b1;
                end
                S_EREQ: begin
                    if (ext_gnt_i) begin
                        state_q   <= S_EGNT;
                        ext_req_q <= 1'b0;
                        gnt_q     <= 1'b1;
                    end else if (tmo_hit) begin
                        state_q   <= S_RESP;
                        ext_req_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                S_EGNT: begin
                    state_q <= S_EWAIT;
                    tmo_q   <= '0;
                end
                S_EWAIT: begin
                    if (ext_rvalid_i) begin
                        state_q     <= S_RESP;
                        ext_rdata_q <= ext_rdata_i;
                        rvalid_q    <= 1'b1;
                    end else if (tmo_hit) begin
                        state_q     <= S_RESP;
                        rvalid_q    <= 1'b1;
                        stale_q     <= 1'b1;
                        stale_cnt_q <= '0;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Local read data is taken live from the slave during the response
    // cycle; the slave has had one cycle since the strobe.
    always_comb begin
        rdata_o = '0;
        if (rvalid_q) begin
            if (err_q) begin
                rdata_o = ERR_RDATA;
            end else if (ext_q) begin
                rdata_o = ext_rdata_q;
            end else begin
                unique case (1'b1)
                    sel_q[0]: rdata_o = ram_rdata_i;
                    sel_q[1]: rdata_o = flash_rdata_i;
                    sel_q[2]: rdata_o = uart_rdata_i;
                    default:  rdata_o = '0;
                endcase
            end
        end
    end

    assign gnt_o        = gnt_q;
    assign rvalid_o     = rvalid_q;
    assign err_o        = err_q;
    assign loc_sel_o    = sel_q;
    assign loc_strobe_o = strobe_q;
    assign loc_addr_o   = addr_q;
    assign loc_we_o     = we_q;
    assign loc_be_o     = be_q;
    assign loc_wdata_o  = wdata_q;
    assign ext_req_o    = ext_req_q;
    assign err_cnt_o    = err_cnt_q;
    assign err_addr_o   = err_addr_q;

endmodule

// File: tb/tb_soc_bus_sequencer.sv
// Directed bench for soc_bus_sequencer with a response scoreboard.
// Expected {err, rdata} pairs are queued at request time, checked on rvalid.
module tb_soc_bus_sequencer;

    localparam int unsigned T = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt_o, rvalid_o, err_o;
    logic [31:0] rdata_o;
    logic [2:0]  loc_sel_o;
    logic        loc_strobe_o, loc_we_o;
    logic [31:0] loc_addr_o, loc_wdata_o;
    logic [3:0]  loc_be_o;
    logic [31:0] ram_q;
    logic [31:0] flash_rdata, uart_rdata;
    logic        ext_req_o;
    logic        ext_gnt, ext_rvalid;
    logic [31:0] ext_rdata;
    logic [7:0]  err_cnt_o;
    logic [31:0] err_addr_o;

    int nchk = 0;
    int nfail = 0;
    int gnt_cnt = 0;
    int rv_cnt = 0;
    logic [32:0] expq[$];

    always #5 clk = ~clk;

    soc_bus_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req), .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .loc_sel_o(loc_sel_o), .loc_strobe_o(loc_strobe_o),
        .loc_addr_o(loc_addr_o), .loc_we_o(loc_we_o),
        .loc_be_o(loc_be_o), .loc_wdata_o(loc_wdata_o),
        .ram_rdata_i(ram_q), .flash_rdata_i(flash_rdata),
        .uart_rdata_i(uart_rdata),
        .ext_req_o(ext_req_o), .ext_gnt_i(ext_gnt),
        .ext_rvalid_i(ext_rvalid), .ext_rdata_i(ext_rdata),
        .err_cnt_o(err_cnt_o), .err_addr_o(err_addr_o)
    );

    // Slave models: RAM answers one cycle after the strobe.
    always @(posedge clk) begin
        if (loc_strobe_o) ram_q <= 32'h1234_5668 + loc_addr_o;
    end
    assign flash_rdata = {16'hF1A5, loc_addr_o[15:0]};
    assign uart_rdata  = 32'h0000_00AA;

    function automatic logic [32:0] model(input logic [31:0] a,
                                          input logic [31:0] xd);
        case (a[31:24])
            8'h00:        return {1'b0, 32'h1234_5668 + a};
            8'h02:        return {1'b0, 16'hF1A5, a[15:0]};
            8'h0A:        return {1'b0, 32'h0000_00AA};
            8'h0E, 8'h0F: return {1'b0, xd};
            default:      return {1'b1, 32'hBAD0_BAD0};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n === 1'b1) begin
            if (gnt_o) gnt_cnt++;
            if (rvalid_o) begin
                rv_cnt++;
                if (expq.size() == 0) begin
                    chk("unexpected_rvalid", 64'd1, 64'd0);
                end else begin
                    e = expq.pop_front();
                    chk("resp", {31'b0, err_o, rdata_o}, {31'b0, e});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic loc_txn(input logic [31:0] a, input logic w,
                           input logic [2:0] sel);
        req = 1'b1; addr = a; we = w; be = 4'hF; wdata = ~a;
        expq.push_back(model(a, 32'h0));
        step();
        req = 1'b0;
        chk("gnt", {63'b0, gnt_o}, 64'd1);
        chk("strobe", {63'b0, loc_strobe_o}, {63'b0, |sel});
        chk("sel", {61'b0, loc_sel_o}, {61'b0, sel});
        chk("loc_we", {63'b0, loc_we_o}, {63'b0, w});
        chk("loc_addr", {32'b0, loc_addr_o}, {32'b0, a});
        step();
        chk("rvalid", {63'b0, rvalid_o}, 64'd1);
        chk("gnt_low", {63'b0, gnt_o}, 64'd0);
        step();
    endtask

    initial begin
        int g0, r0;
        rst_n = 1'b0; req = 0; addr = 0; we = 0; be = 0; wdata = 0;
        ext_gnt = 0; ext_rvalid = 0; ext_rdata = 0; ram_q = 0;
        #1;
        chk("rst_pulses", {60'b0, gnt_o, rvalid_o, loc_strobe_o, ext_req_o}, 64'd0);
        chk("rst_err_cnt", {56'b0, err_cnt_o}, 64'd0);
        chk("rst_loc_addr", {32'b0, loc_addr_o}, 64'd0);
        chk("rst_rdata", {32'b0, rdata_o}, 64'd0);
        #20 rst_n = 1'b1;
        step();

        loc_txn(32'h0000_0010, 1'b0, 3'b001);
        loc_txn(32'h0200_0004, 1'b1, 3'b010);
        loc_txn(32'h0A00_0000, 1'b0, 3'b100);

        // Back-to-back RAM reads with req held.
        g0 = gnt_cnt; r0 = rv_cnt;
        req = 1'b1; addr = 32'h20; we = 0;
        expq.push_back(model(addr, 0));
        for (int i = 0; i < 4; i++) begin
            step();
            chk("b2b_gnt", {63'b0, gnt_o}, 64'd1);
            step();
            chk("b2b_rvalid", {63'b0, rvalid_o}, 64'd1);
            if (i < 3) begin
                addr = 32'h20 + 32'(4 * (i + 1));
                expq.push_back(model(addr, 0));
            end else begin
                req = 1'b0;
            end
        end
        step();
        chk("b2b_gnt_count", 64'(gnt_cnt - g0), 64'd4);
        chk("b2b_rv_count", 64'(rv_cnt - r0), 64'd4);

        // Unmapped read and write.
        loc_txn(32'h5000_0000, 1'b0, 3'b000);
        chk("unm_err_cnt", {56'b0, err_cnt_o}, 64'd1);
        chk("unm_err_addr", {32'b0, err_addr_o}, 64'h5000_0000);
        loc_txn(32'h5100_0000, 1'b1, 3'b000);
        chk("unm_w_err_cnt", {56'b0, err_cnt_o}, 64'd2);

        // I2C read: grant in 3rd request cycle, rvalid in 5th wait cycle.
        req = 1'b1; addr = 32'h0E00_0000; we = 0;
        expq.push_back(model(addr, 32'h0000_00A5));
        step();
        req = 1'b0;
        chk("ext_req", {63'b0, ext_req_o}, 64'd1);
        step();
        chk("ext_no_gnt", {63'b0, gnt_o}, 64'd0);
        step();
        ext_gnt = 1'b1;
        step();
        ext_gnt = 1'b0;
        chk("ext_gnt", {62'b0, gnt_o, ext_req_o}, 64'b10);
        step();
        for (int i = 0; i < 4; i++) step();
        ext_rvalid = 1'b1; ext_rdata = 32'h0000_00A5;
        step();
        ext_rvalid = 1'b0;
        chk("ext_rvalid", {63'b0, rvalid_o}, 64'd1);
        step();

        // Grant timeout: request held exactly T cycles.
        req = 1'b1; addr = 32'h0F00_0100;
        expq.push_back(model(32'h5000_0000, 0));
        step();
        req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("tmo_req_high", {63'b0, ext_req_o}, 64'd1);
            step();
        end
        chk("tmo_req_drop", {61'b0, ext_req_o, rvalid_o, err_o}, 64'b011);
        step();
        chk("tmo_err_cnt", {56'b0, err_cnt_o}, 64'd3);
        chk("tmo_err_addr", {32'b0, err_addr_o}, 64'h0F00_0100);

        // Response timeout leaves the late rvalid pending.
        req = 1'b1; addr = 32'h0E00_0200;
        expq.push_back(model(32'h5000_0000, 0));
        step();
        req = 1'b0; ext_gnt = 1'b1;
        step();
        ext_gnt = 1'b0;
        step();
        for (int i = 0; i < 8; i++) step();
        chk("rtmo_resp", {62'b0, rvalid_o, err_o}, 64'b11);
        step();
        loc_txn(32'h0000_0040, 1'b0, 3'b001);
        req = 1'b1; addr = 32'h0E00_0300;
        expq.push_back(model(addr, 32'h0000_005A));
        step();
        chk("stale_hold", {63'b0, ext_req_o}, 64'd0);
        ext_rvalid = 1'b1; ext_rdata = 32'hDEAD_DEAD;
        step();
        ext_rvalid = 1'b0;
        chk("stale_hold2", {63'b0, ext_req_o}, 64'd0);
        step();
        chk("stale_accept", {63'b0, ext_req_o}, 64'd1);
        req = 1'b0; ext_gnt = 1'b1;
        step();
        ext_gnt = 1'b0;
        step();
        ext_rvalid = 1'b1; ext_rdata = 32'h0000_005A;
        step();
        ext_rvalid = 1'b0;
        chk("after_stale_rvalid", {63'b0, rvalid_o}, 64'd1);
        step();

        // Reset while waiting for the external response.
        r0 = rv_cnt;
        req = 1'b1; addr = 32'h0E00_0400;
        step();
        req = 1'b0; ext_gnt = 1'b1;
        step();
        ext_gnt = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out", {60'b0, gnt_o, rvalid_o, ext_req_o, err_o}, 64'd0);
        chk("rst_mid_cnt", {56'b0, err_cnt_o}, 64'd0);
        #2 rst_n = 1'b1;
        step();
        ext_rvalid = 1'b1; ext_rdata = 32'h1111_1111;
        step();
        ext_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("rst_no_rvalid", 64'(rv_cnt - r0), 64'd0);

        // 256 unmapped accesses saturate the error counter.
        req = 1'b1;
        for (int i = 0; i < 256; i++) begin
            addr = 32'h3000_0000 + 32'(i);
            expq.push_back(model(addr, 0));
            step();
            step();
        end
        req = 1'b0;
        step();
        chk("sat_err_cnt", {56'b0, err_cnt_o}, 64'd255);
        chk("sat_err_addr", {32'b0, err_addr_o}, 64'h3000_00FF);
        chk("queue_empty", 64'(expq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
